// File: rtl/fp_pkg.sv
// Shared floating-point constants and types for the FP pipeline stages.
// Contents:
//   PIO2_FP  - pi/2 as an IEEE-754 single (magnitude bits)
//   PIO2_FIX - pi/2 in Q8.24 fixed point
//   QNAN     - canonical quiet NaN returned for invalid inputs
//   EXP_BIAS - IEEE-754 single exponent bias
//   state_t  - range-reduction controller states
package fp_pkg;

    localparam logic [31:0] PIO2_FP  = 32'h3FC90FDB;
    localparam logic [31:0] PIO2_FIX = 32'h01921FB5;
    localparam logic [31:0] QNAN     = 32'h7FC00000;
    localparam int          EXP_BIAS = 127;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        DIV  = 3'd2,
        NORM = 3'd3,
        PACK = 3'd4
    } state_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational IEEE-754 single unpacker shared by the FP stages.
// Ports:
//   opx        in  32  IEEE-754 single operand
//   sign       out 1   sign bit
//   expo       out 8   biased exponent field
//   mant       out 23  fraction field (hidden bit not included)
//   is_nan_inf out 1   exponent all ones (NaN or infinity)
//   is_small   out 1   |opx| < pi/2 (covers zero and denormals)
//   is_big     out 1   |opx| >= 2^QBITS (also true for NaN/Inf)
module fp_unpack #(
    parameter int QBITS = 7
) (
    input  logic [31:0] opx,
    output logic        sign,
    output logic [7:0]  expo,
    output logic [22:0] mant,
    output logic        is_nan_inf,
    output logic        is_small,
    output logic        is_big
);
    import fp_pkg::*;

    assign sign       = opx[31];
    assign expo       = opx[30:23];
    assign mant       = opx[22:0];
    assign is_nan_inf = (opx[30:23] == 8'hFF);
    // Any exponent at or above bias+QBITS means the magnitude is at least 2^QBITS.
    assign is_big     = ({1'b0, opx[30:23]} >= 9'(EXP_BIAS + QBITS));
    // Positive IEEE magnitudes order the same as their bit patterns.
    assign is_small   = (opx[30:0] < PIO2_FP[30:0]);

endmodule

// File: rtl/fp_range_reduce.sv
// Argument reduction of an IEEE-754 single angle modulo pi/2, feeding sincos.
// |x| is converted to Q8.24, divided by pi/2 with a restoring divider (one
// quotient bit per cycle), and the remainder is renormalised to a float.
// Ports:
//   clk      in  1   system clock
//   n_rst    in  1   asynchronous active-low reset
//   start    in  1   one-cycle request, sampled only in IDLE
//   opx      in  32  IEEE-754 single angle (radians)
//   busy     out 1   high while the slow path is running
//   done     out 1   one-cycle pulse when results are valid
//   opx_out  out 32  reduced angle in [0, pi/2), IEEE-754 single
//   quadrant out 2   floor(|x| / (pi/2)) mod 4
//   neg      out 1   sign of the input
//   invalid  out 1   input was NaN, Inf or |x| >= 2^QBITS
module fp_range_reduce #(
    parameter int QBITS = 7,
    parameter int FRAC  = 24
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic [31:0] opx,
    output logic        busy,
    output logic        done,
    output logic [31:0] opx_out,
    output logic [1:0]  quadrant,
    output logic        neg,
    output logic        invalid
);
    import fp_pkg::*;

    localparam int KW = (QBITS > 2) ? $clog2(QBITS) : 2;

    logic        u_sign_s;
    logic [7:0]  u_expo_s;
    logic [22:0] u_mant_s;
    logic        u_nan_inf_s;
    logic        u_small_s;
    logic        u_big_s;

    fp_unpack #(.QBITS(QBITS)) u_unpack (
        .opx        (opx),
        .sign       (u_sign_s),
        .expo       (u_expo_s),
        .mant       (u_mant_s),
        .is_nan_inf (u_nan_inf_s),
        .is_small   (u_small_s),
        .is_big     (u_big_s)
    );

    state_t          state_r;
    state_t          state_s;
    logic [31:0]     rem_r;
    logic [7:0]      exp_r;
    logic [KW-1:0]   k_r;
    // Only q mod 4 is needed downstream, so upper quotient bits are not kept.
    logic [1:0]      q_r;
    logic            neg_cap_r;

    logic            slow_s;
    logic            fast_bad_s;
    logic [31:0]     div_s;
    logic            take_s;
    logic [7:0]      shamt_s;

    assign fast_bad_s = u_nan_inf_s | u_big_s;
    assign slow_s     = start & ~fast_bad_s & ~u_small_s;
    assign div_s      = PIO2_FIX << k_r;
    assign take_s     = (rem_r >= div_s);
    // {1,mant} has 23 fraction bits; align to FRAC bits and scale by 2^(exp-bias).
    assign shamt_s    = exp_r - 8'(EXP_BIAS + 23 - FRAC);

    // Next-state logic of the reduction controller.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (slow_s) state_s = LOAD;
                else        state_s = IDLE;
            end
            LOAD: state_s = DIV;
            DIV: begin
                if (k_r == {KW{1'b0}}) state_s = NORM;
                else                   state_s = DIV;
            end
            NORM: begin
                if ((rem_r == 32'd0) || rem_r[FRAC]) state_s = PACK;
                else                                 state_s = NORM;
            end
            PACK:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_r <= IDLE;
        else        state_r <= state_s;
    end

    // Datapath: operand capture, load shift, restoring divide and normalisation.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rem_r     <= 32'd0;
            exp_r     <= 8'd0;
            k_r       <= {KW{1'b0}};
            q_r       <= 2'b00;
            neg_cap_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        neg_cap_r <= u_sign_s;
                        exp_r     <= u_expo_s;
                        rem_r     <= {9'd0, u_mant_s};
                    end
                end
                LOAD: begin
                    rem_r <= {8'd0, 1'b1, rem_r[22:0]} << shamt_s;
                    exp_r <= 8'(EXP_BIAS);
                    k_r   <= KW'(QBITS - 1);
                    q_r   <= 2'b00;
                end
                DIV: begin
                    if (take_s) begin
                        rem_r <= rem_r - div_s;
                        if (k_r < KW'(2)) q_r[k_r[0]] <= 1'b1;
                    end
                    k_r <= k_r - KW'(1);
                end
                NORM: begin
                    // A zero remainder packs as +0.0, so the exponent is forced to 0.
                    if (rem_r == 32'd0) begin
                        exp_r <= 8'd0;
                    end else if (!rem_r[FRAC]) begin
                        rem_r <= rem_r << 1;
                        exp_r <= exp_r - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered outputs: fast paths publish on the accept edge, slow path in PACK.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            opx_out  <= 32'd0;
            quadrant <= 2'b00;
            neg      <= 1'b0;
            invalid  <= 1'b0;
        end else begin
            busy <= (state_s != IDLE);
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start && fast_bad_s) begin
                        done     <= 1'b1;
                        opx_out  <= QNAN;
                        quadrant <= 2'b00;
                        neg      <= u_sign_s;
                        invalid  <= 1'b1;
                    end else if (start && u_small_s) begin
                        done     <= 1'b1;
                        opx_out  <= {1'b0, opx[30:0]};
                        quadrant <= 2'b00;
                        neg      <= u_sign_s;
                        invalid  <= 1'b0;
                    end
                end
                PACK: begin
                    done     <= 1'b1;
                    opx_out  <= {1'b0, exp_r, rem_r[FRAC-1 -: 23]};
                    quadrant <= q_r;
                    neg      <= neg_cap_r;
                    invalid  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
